// File: rtl/rca_result_checker_if.sv
// ----------------------------------------------------------------------------
// rca_result_checker_if
// Bus from the ripple-carry adder test harness into the result checker: the
// operand vector applied to the adder, the adder's response, and a valid
// qualifier.
//   in_valid : operands and adder results are valid this cycle
//   op_a     : operand A (a..d, MSB first)
//   op_b     : operand B (e..h, MSB first)
//   cin      : carry-in
//   dut_sum  : adder sum (s1..s4)
//   dut_cout : adder carry-out (pc4)
// master = stimulus/adder side, slave = checker side.
// ----------------------------------------------------------------------------
interface rca_result_checker_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_cout;

    modport master (output in_valid, op_a, op_b, cin, dut_sum, dut_cout);
    modport slave  (input  in_valid, op_a, op_b, cin, dut_sum, dut_cout);
endinterface

// File: rtl/rca_result_checker.sv
// ----------------------------------------------------------------------------
// rca_result_checker
// Response checker for a WIDTH-bit ripple-carry adder driven by a counting
// stimulus generator. Each valid vector is registered (stage 1) and compared
// on the next edge (stage 2) against op_a + op_b + cin. Mismatches and
// out-of-order vectors are counted; pass/fail is reported once NUM_VEC
// vectors have been compared.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : one-cycle pulse, starts/restarts a sweep (ignored in RUN)
//   vin              : adder bus (rca_result_checker_if.slave)
//   busy             : high while a sweep is running
//   done / pass      : sweep finished / no errors (valid while done=1)
//   err_count        : sum/carry mismatches, saturating
//   vec_count        : vectors compared in this sweep
//   order_err        : sticky, a vector arrived out of counting order
//   first_fail_vec   : {op_a, op_b, cin} of the first sum/carry mismatch
//   first_fail_valid : first_fail_vec holds a captured vector
//
// Optional build macro RCA_CHK_STOP_ON_FAIL_EN: the first mismatch (sum/carry
// or order) ends the sweep on its compare edge with pass=0.
// ----------------------------------------------------------------------------
module rca_result_checker #(
    parameter int WIDTH   = 4,
    parameter int NUM_VEC = 2**(2*WIDTH+1),
    parameter int ERR_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    rca_result_checker_if.slave     vin,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_W-1:0]        err_count,
    output logic [2*WIDTH+1:0]      vec_count,
    output logic                    order_err,
    output logic [2*WIDTH:0]        first_fail_vec,
    output logic                    first_fail_valid
);
    localparam int VC_W  = 2*WIDTH + 2;
    localparam int VEC_W = 2*WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;

    logic               s1_valid_r, s1_valid_s;
    logic [WIDTH-1:0]   s1_a_r, s1_b_r, s1_sum_r;
    logic               s1_cin_r, s1_cout_r;

    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               pass_r, pass_s;
    logic [ERR_W-1:0]   err_count_r, err_count_s;
    logic [VC_W-1:0]    vec_count_r, vec_count_s;
    logic               order_err_r, order_err_s;
    logic [VEC_W-1:0]   first_fail_vec_r, first_fail_vec_s;
    logic               first_fail_valid_r, first_fail_valid_s;

    logic [WIDTH:0]     exp_s;
    logic [VEC_W-1:0]   vec_s;
    logic               cmp_s, sum_bad_s, ord_bad_s;
    logic               start_run_s, finish_s;

    // Reference sum and mismatch detection for the vector held in stage 1
    always_comb begin
        exp_s     = {1'b0, s1_a_r} + {1'b0, s1_b_r} + {{WIDTH{1'b0}}, s1_cin_r};
        vec_s     = {s1_a_r, s1_b_r, s1_cin_r};
        cmp_s     = (state_r == ST_RUN) && s1_valid_r;
        sum_bad_s = cmp_s && ({s1_cout_r, s1_sum_r} != exp_s);
        ord_bad_s = cmp_s && (vec_s != vec_count_r[VEC_W-1:0]);
    end

    // Next state and next values of the counters and result flags
    always_comb begin
        state_s            = state_r;
        start_run_s        = 1'b0;
        finish_s           = 1'b0;
        done_s             = done_r;
        pass_s             = pass_r;
        err_count_s        = err_count_r;
        vec_count_s        = vec_count_r;
        order_err_s        = order_err_r;
        first_fail_vec_s   = first_fail_vec_r;
        first_fail_valid_s = first_fail_valid_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    start_run_s = 1'b1;
                end else begin
                    start_run_s = 1'b0;
                end
            end
            ST_RUN: begin
                if (cmp_s) begin
                    vec_count_s = vec_count_r + {{(VC_W-1){1'b0}}, 1'b1};
                    if (sum_bad_s && (err_count_r != {ERR_W{1'b1}})) begin
                        err_count_s = err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
                    end else begin
                        err_count_s = err_count_r;
                    end
                    if (sum_bad_s && !first_fail_valid_r) begin
                        first_fail_vec_s   = vec_s;
                        first_fail_valid_s = 1'b1;
                    end else begin
                        first_fail_vec_s   = first_fail_vec_r;
                        first_fail_valid_s = first_fail_valid_r;
                    end
                    if (ord_bad_s) begin
                        order_err_s = 1'b1;
                    end else begin
                        order_err_s = order_err_r;
                    end
`ifdef RCA_CHK_STOP_ON_FAIL_EN
                    finish_s = (vec_count_s == VC_W'(NUM_VEC)) || sum_bad_s || ord_bad_s;
`else
                    finish_s = (vec_count_s == VC_W'(NUM_VEC));
`endif
                end else begin
                    finish_s = 1'b0;
                end
            end
            ST_DONE: begin
                if (start) begin
                    start_run_s = 1'b1;
                end else begin
                    start_run_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A new sweep wipes every result; a finishing sweep latches the verdict
        // from the same-edge counter values so done/pass line up with vec_count.
        if (start_run_s) begin
            state_s            = ST_RUN;
            done_s             = 1'b0;
            pass_s             = 1'b0;
            err_count_s        = {ERR_W{1'b0}};
            vec_count_s        = {VC_W{1'b0}};
            order_err_s        = 1'b0;
            first_fail_vec_s   = {VEC_W{1'b0}};
            first_fail_valid_s = 1'b0;
        end else if (finish_s) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            pass_s  = (err_count_s == {ERR_W{1'b0}}) && !order_err_s;
        end else begin
            state_s = state_s;
        end

        // Stage 1 only loads in RUN; anything captured on the finishing edge
        // is never compared because the state has already left RUN.
        s1_valid_s = (state_r == ST_RUN) && vin.in_valid && !finish_s;
        busy_s     = (state_s == ST_RUN);
    end

    // State, pipeline and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r            <= ST_IDLE;
            s1_valid_r         <= 1'b0;
            s1_a_r             <= {WIDTH{1'b0}};
            s1_b_r             <= {WIDTH{1'b0}};
            s1_cin_r           <= 1'b0;
            s1_sum_r           <= {WIDTH{1'b0}};
            s1_cout_r          <= 1'b0;
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
            pass_r             <= 1'b0;
            err_count_r        <= {ERR_W{1'b0}};
            vec_count_r        <= {VC_W{1'b0}};
            order_err_r        <= 1'b0;
            first_fail_vec_r   <= {VEC_W{1'b0}};
            first_fail_valid_r <= 1'b0;
        end else begin
            state_r            <= state_s;
            s1_valid_r         <= s1_valid_s;
            if (s1_valid_s) begin
                s1_a_r    <= vin.op_a;
                s1_b_r    <= vin.op_b;
                s1_cin_r  <= vin.cin;
                s1_sum_r  <= vin.dut_sum;
                s1_cout_r <= vin.dut_cout;
            end
            busy_r             <= busy_s;
            done_r             <= done_s;
            pass_r             <= pass_s;
            err_count_r        <= err_count_s;
            vec_count_r        <= vec_count_s;
            order_err_r        <= order_err_s;
            first_fail_vec_r   <= first_fail_vec_s;
            first_fail_valid_r <= first_fail_valid_s;
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_count        = err_count_r;
    assign vec_count        = vec_count_r;
    assign order_err        = order_err_r;
    assign first_fail_vec   = first_fail_vec_r;
    assign first_fail_valid = first_fail_valid_r;

endmodule

// File: tb/tb_rca_result_checker.sv
// ----------------------------------------------------------------------------
// tb_rca_result_checker
// Self-checking bench for rca_result_checker (WIDTH=4, 512-vector sweep).
// A table of fault/skip scenarios with hand-derived expectations, hand-written
// reset/latency/restart sequences, and randomized sweeps judged by a queue
// model that derives results from the list of vectors sent.
// ----------------------------------------------------------------------------
module tb_rca_result_checker;
    localparam int W  = 4;
    localparam int NV = 512;
    localparam int EW = 16;
`ifdef RCA_CHK_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            busy, done, pass, order_err, first_fail_valid;
    logic [EW-1:0]   err_count;
    logic [2*W+1:0]  vec_count;
    logic [2*W:0]    first_fail_vec;

    rca_result_checker_if #(.WIDTH(W)) vif();

    rca_result_checker #(.WIDTH(W), .NUM_VEC(NV), .ERR_W(EW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .vin              (vif),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .vec_count        (vec_count),
        .order_err        (order_err),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [8:0] vec;
        logic [4:0] res;
    } rec_t;
    rec_t q[$];

    typedef struct {
        int         fault;
        logic [4:0] x;
        int         skip;
        bit         gaps;
        int         e_err;
        int         e_vc;
        bit         e_ord;
        bit         e_ffv;
        logic [8:0] e_ff;
    } tv_t;
    tv_t tbl[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one vector for one cycle (optionally after a random idle gap)
    task automatic send(input logic [8:0] v, input logic [4:0] x, input bit gaps);
        logic [31:0] rnd;
        logic [4:0]  r;
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            repeat ($urandom_range(1, 3)) begin
                rnd = $urandom;
                vif.in_valid = 1'b0;
                vif.op_a = rnd[3:0];
                vif.op_b = rnd[7:4];
                vif.cin  = rnd[8];
                vif.dut_sum = rnd[12:9];
                vif.dut_cout = rnd[13];
                cyc();
            end
        end
        r = ({1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0000, v[0]}) ^ x;
        vif.op_a = v[8:5];
        vif.op_b = v[4:1];
        vif.cin  = v[0];
        vif.dut_sum  = r[3:0];
        vif.dut_cout = r[4];
        vif.in_valid = 1'b1;
        q.push_back('{v, r});
        cyc();
        vif.in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        q.delete();
    endtask

    task automatic sweep(input int fault, input logic [4:0] x, input int skip, input bit gaps);
        for (int v = 0; v < NV; v++) begin
            if (v != skip) send(v[8:0], (v == fault) ? x : 5'd0, gaps);
        end
        if (skip >= 0) send(skip[8:0], (skip == fault) ? x : 5'd0, gaps);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_done_reached"}, done, 1);
    endtask

    // Reference: judge the sent vectors directly by position and arithmetic
    task automatic model_eval(output int e_err, output int e_vc, output bit e_ord,
                              output bit e_ffv, output logic [8:0] e_ff);
        logic [4:0] rf;
        bit sb, ob;
        e_err = 0; e_vc = 0; e_ord = 0; e_ffv = 0; e_ff = 9'd0;
        foreach (q[i]) begin
            if (e_vc >= NV) break;
            rf = {1'b0, q[i].vec[8:5]} + {1'b0, q[i].vec[4:1]} + {4'b0000, q[i].vec[0]};
            sb = (q[i].res != rf);
            ob = (q[i].vec != i[8:0]);
            e_vc++;
            if (sb) begin
                e_err++;
                if (!e_ffv) begin
                    e_ffv = 1'b1;
                    e_ff  = q[i].vec;
                end
            end
            if (ob) e_ord = 1'b1;
            if (STOP && (sb || ob)) break;
        end
    endtask

    task automatic check_all(input string tag, input int e_err, input int e_vc, input bit e_ord,
                             input bit e_ffv, input logic [8:0] e_ff);
        chk({tag, "_err_count"}, err_count, e_err);
        chk({tag, "_vec_count"}, vec_count, e_vc);
        chk({tag, "_order_err"}, order_err, e_ord);
        chk({tag, "_ff_valid"}, first_fail_valid, e_ffv);
        chk({tag, "_ff_vec"}, first_fail_vec, e_ff);
        chk({tag, "_pass"}, pass, (e_err == 0) && !e_ord);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_vec_count"}, vec_count, 0);
        chk({tag, "_order_err"}, order_err, 0);
        chk({tag, "_ff_vec"}, first_fail_vec, 0);
        chk({tag, "_ff_valid"}, first_fail_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e_err, e_vc, fault, skip;
        bit e_ord, e_ffv;
        logic [8:0] e_ff;
        logic [31:0] rnd;

        tbl[0] = '{-1,  5'h00, -1, 1'b0, 0, 512,              1'b0, 1'b0, 9'h000};
        tbl[1] = '{165, 5'h0F, -1, 1'b0, 1, STOP ? 166 : 512, 1'b0, 1'b1, 9'h0A5};
        tbl[2] = '{-1,  5'h00, 16, 1'b1, 0, STOP ? 17 : 512,  1'b1, 1'b0, 9'h000};
        tbl[3] = '{3,   5'h10, -1, 1'b1, 1, STOP ? 4 : 512,   1'b0, 1'b1, 9'h003};

        vif.in_valid = 1'b0; vif.op_a = 4'd0; vif.op_b = 4'd0;
        vif.cin = 1'b0; vif.dut_sum = 4'd0; vif.dut_cout = 1'b0;

        // Reset, then idle traffic without start must leave everything at 0
        repeat (2) cyc();
        check_zero("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rnd = $urandom;
            send(rnd[8:0], 5'd0, 1'b0);
        end
        check_zero("idle_no_start");

        // Asynchronous reset in the middle of a sweep
        do_start();
        for (int v = 0; v < 100; v++) send(v[8:0], 5'd0, 1'b0);
        cyc();
        chk("mid_vec_count", vec_count, 100);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Clean back-to-back sweep with latency and dropped trailing pulse
        do_start();
        chk("start_busy", busy, 1);
        chk("start_vec_count", vec_count, 0);
        for (int v = 0; v < NV; v++) send(v[8:0], 5'd0, 1'b0);
        chk("lat_done_early", done, 0);
        chk("lat_busy_early", busy, 1);
        vif.op_a = 4'd0; vif.op_b = 4'd0; vif.cin = 1'b0;
        vif.dut_sum = 4'd0; vif.dut_cout = 1'b0;
        vif.in_valid = 1'b1;
        cyc();
        vif.in_valid = 1'b0;
        check_all("clean", 0, 512, 1'b0, 1'b0, 9'h000);
        repeat (3) cyc();
        chk("trailing_drop_vc", vec_count, 512);
        for (int i = 0; i < 4; i++) send(i[8:0], 5'h1F, 1'b0);
        chk("done_ignore_vc", vec_count, 512);
        chk("done_ignore_err", err_count, 0);
        chk("done_held", done, 1);

        // Restart from DONE clears results, then a gapped clean sweep
        do_start();
        chk("restart_done", done, 0);
        chk("restart_pass", pass, 0);
        chk("restart_busy", busy, 1);
        chk("restart_vc", vec_count, 0);
        sweep(-1, 5'd0, -1, 1'b1);
        wait_done("gapped");
        model_eval(e_err, e_vc, e_ord, e_ffv, e_ff);
        check_all("gapped", e_err, e_vc, e_ord, e_ffv, e_ff);

        // Table-driven fault/order scenarios
        for (int i = 0; i < 4; i++) begin
            do_start();
            sweep(tbl[i].fault, tbl[i].x, tbl[i].skip, tbl[i].gaps);
            wait_done($sformatf("tbl%0d", i));
            check_all($sformatf("tbl%0d", i), tbl[i].e_err, tbl[i].e_vc, tbl[i].e_ord,
                      tbl[i].e_ffv, tbl[i].e_ff);
        end

        // Randomized faults/skips against the queue model
        for (int k = 0; k < 3; k++) begin
            fault = $urandom_range(0, NV - 1);
            rnd   = $urandom;
            skip  = (k == 0) ? -1 : int'($urandom_range(1, NV - 2));
            do_start();
            sweep(fault, (rnd[4:0] == 5'd0) ? 5'd1 : rnd[4:0], skip, 1'b1);
            wait_done($sformatf("rand%0d", k));
            model_eval(e_err, e_vc, e_ord, e_ffv, e_ff);
            check_all($sformatf("rand%0d", k), e_err, e_vc, e_ord, e_ffv, e_ff);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rca_result_checker.md
Name: rca_result_checker

Overview:
- Synthesizable response checker that sits on the output side of the ripple-carry adder.
- It samples each applied operand vector together with the adder's sum and carry-out, and computes a reference sum with behavioural addition.
- It counts mismatches and out-of-order vectors, and reports pass/fail once the full exhaustive sweep of 2^(2*WIDTH+1) vectors has been observed.
- It is the consumer end of the counting stimulus generator, so the stimulus order {op_a, op_b, cin} from 0 upward is checked as well.

Parameters:
- WIDTH, 4, adder operand width in bits.
- NUM_VEC, 2**(2*WIDTH+1), number of vectors in a full sweep (512 at default).
- ERR_W, 16, width of the error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; starts or restarts a sweep
- in_valid  input  1  operands and DUT results are valid this cycle
- op_a  input  WIDTH  operand A applied to the adder (a..d, MSB first)
- op_b  input  WIDTH  operand B applied to the adder (e..h, MSB first)
- cin  input  1  carry-in applied to the adder
- dut_sum  input  WIDTH  adder sum (s1..s4)
- dut_cout  input  1  adder carry-out (pc4)
- busy  output  1  high while in RUN
- done  output  1  sweep finished; held until the next start
- pass  output  1  valid when done=1; 1 iff err_count==0 and order_err==0
- err_count  output  ERR_W  number of sum/carry mismatches; saturates at all-ones
- vec_count  output  2*WIDTH+2  number of vectors compared
- order_err  output  1  sticky; a vector arrived out of counting order
- first_fail_vec  output  2*WIDTH+1  {op_a, op_b, cin} of the first mismatch
- first_fail_valid  output  1  first_fail_vec holds a captured value

Behaviour:
- Reset: rst_n=0 clears all outputs and pipeline registers immediately to 0, and the state goes to IDLE. This applies mid-sweep as well; nothing is retained.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE when the compare of vector NUM_VEC-1 completes, i.e. vec_count reaches NUM_VEC.
  - DONE -> RUN on start.
  - start while in RUN is ignored.
- Entering RUN clears err_count, vec_count, order_err, first_fail_* and done.
- in_valid is ignored in IDLE and in DONE.
- Pipeline stage 1: on a clk edge with in_valid=1 in RUN, op_a, op_b, cin, dut_sum and dut_cout are registered into stage 1, along with a stage-1 valid bit.
- Pipeline stage 2, on the next edge:
  - Expected result is {exp_cout, exp_sum} = op_a + op_b + cin, computed in WIDTH+1 bits with no truncation.
  - A mismatch on either field increments err_count, saturating at all-ones. On the first mismatch only, the vector is latched into first_fail_vec and first_fail_valid is set.
  - The vector {op_a, op_b, cin} is compared against vec_count[2*WIDTH:0]; inequality sets order_err.
  - vec_count increments by 1.
- Latency: counter and flag updates are visible 2 clk edges after the in_valid sample edge.
- Gaps in in_valid are allowed; the pipeline only advances on valid data. Back-to-back valid data is accepted at a rate of 1 per cycle.
- done and pass are registered and assert on the same edge as the final vec_count update, entering DONE. busy deasserts on that edge.
- Any in_valid pulse in the cycle after the last vector is dropped.

Optional Feature:
- Macro: RCA_CHK_STOP_ON_FAIL_EN.
- When defined: the first mismatch (sum/carry or order) forces RUN -> DONE on the compare edge. done=1, pass=0, and vec_count includes the failing vector. Any vector already in stage 1 is discarded.
- When undefined: the checker always runs the full NUM_VEC sweep.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs 0 asynchronously. Release, hold 5 cycles without start -> outputs remain 0.
- Clean sweep: start, then 512 consecutive vectors 0..511 with dut_sum/dut_cout driven from a correct model -> done=1, pass=1, err_count=0, vec_count=512. busy=0 on the done edge, 2 cycles after the last in_valid.
- Injected fault: correct model except vector 0x0A5 (a=0101, b=0010, cin=1) drives dut_sum=0x7 instead of 0x8 -> err_count=1, first_fail_vec=0x0A5, first_fail_valid=1, pass=0 at done.
- Order/gaps: random 1-3 cycle gaps on in_valid plus a skipped vector 0x010 -> order_err=1, pass=0, err_count=0. in_valid pulses before start leave vec_count=0.
- Restart: reset mid-sweep at vec_count=100, then start and run a full clean sweep -> pass=1, vec_count=512. A start pulse in DONE clears the counters and starts a new sweep.
- With RCA_CHK_STOP_ON_FAIL_EN: dut_cout forced wrong at vector 3 -> done=1, pass=0, vec_count=4, err_count=1, and later vectors are ignored.
